// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM loader: bus widths and the FSM state encoding.
package ram_loader_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    SET_ADDR,
    WRITE,
    READBACK,
    CHECK,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/ram_loader_if.sv
// Byte-source handshake, RAM control strobes and loader status, bundled as one port.
interface ram_loader_if;
  import ram_loader_pkg::*;

  logic              start;
  logic [DATA_W-1:0] byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] addr_out;
  logic              addr_en;
  logic              load;
  logic              dataout_en;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] err_addr;
  logic [DATA_W-1:0] checksum;

  // Loader side
  modport master (
    input  start, byte_in, byte_valid,
    output byte_ready, addr_out, addr_en, load, dataout_en,
    output busy, done, error, err_addr, checksum
  );

  // Source / RAM / supervisor side
  modport slave (
    output start, byte_in, byte_valid,
    input  byte_ready, addr_out, addr_en, load, dataout_en,
    input  busy, done, error, err_addr, checksum
  );

endinterface

// File: rtl/ram_loader.sv
// Loads DEPTH bytes from a valid/ready source into a RAM over a shared tri-state
// bus, optionally reading every word back and stopping at the first mismatch.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter bit VERIFY = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  ram_loader_if.master      bus,
  inout  wire  [DATA_W-1:0] data
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] err_addr;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] rb;
  logic [DATA_W-1:0] checksum;
  logic              take;
  logic              mismatch;

  // byte_ready is high exactly in WAIT_BYTE, so the handshake reduces to this
  assign take     = (state == WAIT_BYTE) && bus.byte_valid;
  assign mismatch = VERIFY && (rb != hold);

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and Moore strobes; every strobe is a pure state decode
  always_comb begin
    state_next     = state;
    bus.byte_ready = 1'b0;
    bus.addr_en    = 1'b0;
    bus.load       = 1'b0;
    bus.dataout_en = 1'b0;
    bus.busy       = 1'b1;
    bus.done       = 1'b0;
    bus.error      = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_next = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        bus.byte_ready = 1'b1;
        if (take) state_next = SET_ADDR;
      end
      SET_ADDR: begin
        bus.addr_en = 1'b1;
        state_next  = WRITE;
      end
      WRITE: begin
        bus.load   = 1'b1;
        state_next = VERIFY ? READBACK : CHECK;
      end
      READBACK: begin
        bus.dataout_en = 1'b1;
        state_next     = CHECK;
      end
      CHECK: begin
        if (mismatch)          state_next = ERROR;
        else if (cnt == LAST)  state_next = DONE;
        else                   state_next = WAIT_BYTE;
      end
      DONE: begin
        bus.busy = 1'b0;
        bus.done = 1'b1;
        if (bus.start) state_next = WAIT_BYTE;
      end
      ERROR: begin
        bus.busy  = 1'b0;
        bus.error = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: word counter, held byte, readback capture, checksum, fault address
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt      <= '0;
      hold     <= '0;
      rb       <= '0;
      checksum <= '0;
      err_addr <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            cnt      <= '0;
            checksum <= '0;
          end
        end
        WAIT_BYTE: begin
          if (take) begin
            hold     <= bus.byte_in;
            checksum <= checksum + bus.byte_in;
          end
        end
        READBACK: rb <= data;
        CHECK: begin
          if (mismatch)         err_addr <= cnt;
          else if (cnt != LAST) cnt      <= cnt + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // The loader owns the bus only while writing; the RAM drives it in READBACK
  assign data = (state == WRITE) ? hold : {DATA_W{1'bz}};

  assign bus.addr_out = cnt;
  assign bus.err_addr = err_addr;
  assign bus.checksum = checksum;

endmodule
